// File: rtl/axis_frame_sink.sv
// axis_frame_sink: AXI4-Stream video sink for self-test.
// Drives tready with optional LFSR backpressure, checks SOF/EOF framing,
// counts pixels and frames, and latches a per-frame additive checksum.
module axis_frame_sink #(
  parameter int          WIDTH      = 128,
  parameter int          HEIGHT     = 100,
  parameter int          DATA_WIDTH = 24,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  bp_enable,
  input  logic [7:0]            bp_thresh,
  input  logic                  err_clear,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic [31:0]           last_pixel_count,
  output logic [31:0]           last_checksum,
  output logic                  busy,
  output logic                  err_nosof,
  output logic                  err_sof,
  output logic                  err_eof
);

  localparam logic [31:0] FRAME_LEN = 32'(WIDTH * HEIGHT);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Galois step for x^16+x^14+x^13+x^11 (right-shifting form).
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ 16'hB400;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  logic [15:0] lfsr_r;
  logic [0:0]  state_r;
  logic [31:0] count_r;
  logic [31:0] sum_r;

  logic        accept_s;
  logic [0:0]  state_nxt_s;
  logic [31:0] count_nxt_s;
  logic [31:0] sum_nxt_s;
  logic        close_s;
  logic        set_nosof_s;
  logic        set_sof_s;
  logic        set_eof_s;
  logic [31:0] beat_count_s;
  logic [31:0] beat_sum_s;
  logic [31:0] pix_s;

  assign accept_s     = s_axis_tvalid & s_axis_tready;
  assign pix_s        = 32'(s_axis_tdata);
  assign beat_count_s = count_r + 32'd1;
  assign beat_sum_s   = sum_r + pix_s;

  // Free-running backpressure LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Registered ready: stall when backpressure is on and the LFSR low byte is below threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= !(bp_enable && (lfsr_r[7:0] < bp_thresh));
    end
  end

  // Frame tracking decisions for the beat accepted this cycle.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    sum_nxt_s   = sum_r;
    close_s     = 1'b0;
    set_nosof_s = 1'b0;
    set_sof_s   = 1'b0;
    set_eof_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (s_axis_tuser) begin
            count_nxt_s = 32'd1;
            sum_nxt_s   = pix_s;
            if (s_axis_tlast) begin
              close_s     = 1'b1;
              set_eof_s   = (FRAME_LEN != 32'd1);
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_ACTIVE;
            end
          end else begin
            set_nosof_s = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (s_axis_tuser) begin
            // Unexpected SOF: drop the partial frame and start over on this beat.
            set_sof_s   = 1'b1;
            count_nxt_s = 32'd1;
            sum_nxt_s   = pix_s;
            if (s_axis_tlast) begin
              close_s     = 1'b1;
              set_eof_s   = (FRAME_LEN != 32'd1);
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_ACTIVE;
            end
          end else if (s_axis_tlast) begin
            count_nxt_s = beat_count_s;
            sum_nxt_s   = beat_sum_s;
            close_s     = 1'b1;
            set_eof_s   = (beat_count_s != FRAME_LEN);
            state_nxt_s = ST_IDLE;
          end else if (beat_count_s == FRAME_LEN) begin
            // Frame reached full size without tlast: close it anyway.
            count_nxt_s = beat_count_s;
            sum_nxt_s   = beat_sum_s;
            close_s     = 1'b1;
            set_eof_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            count_nxt_s = beat_count_s;
            sum_nxt_s   = beat_sum_s;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state, running counters and busy indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      count_r <= 32'd0;
      sum_r   <= 32'd0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      sum_r   <= sum_nxt_s;
      busy    <= (state_nxt_s == ST_ACTIVE);
    end
  end

  // Frame close: latch results, bump frame counter, pulse frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done       <= 1'b0;
      frame_count      <= 16'd0;
      last_pixel_count <= 32'd0;
      last_checksum    <= 32'd0;
    end else if (close_s) begin
      frame_done       <= 1'b1;
      frame_count      <= frame_count + 16'd1;
      last_pixel_count <= count_nxt_s;
      last_checksum    <= sum_nxt_s;
    end else begin
      frame_done       <= 1'b0;
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_nosof <= 1'b0;
      err_sof   <= 1'b0;
      err_eof   <= 1'b0;
    end else begin
      err_nosof <= set_nosof_s | (err_nosof & ~err_clear);
      err_sof   <= set_sof_s   | (err_sof   & ~err_clear);
      err_eof   <= set_eof_s   | (err_eof   & ~err_clear);
    end
  end

endmodule

// File: tb/tb_axis_frame_sink.sv
// Scoreboard bench for axis_frame_sink: a small 4x2 instance for framing and
// error cases, and a default-size instance with backpressure for a full frame.
module tb_axis_frame_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Small instance (WIDTH=4, HEIGHT=2)
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tuser, s_tlast, s_tready, s_bp_en, s_err_clr;
  logic [7:0]  s_bp_th;
  logic        s_done, s_busy, s_enosof, s_esof, s_eeof;
  logic [15:0] s_fc;
  logic [31:0] s_lpc, s_lcs;

  // Default-size instance
  logic [23:0] b_tdata;
  logic        b_tvalid, b_tuser, b_tlast, b_tready, b_bp_en, b_err_clr;
  logic [7:0]  b_bp_th;
  logic        b_done, b_busy, b_enosof, b_esof, b_eeof;
  logic [15:0] b_fc;
  logic [31:0] b_lpc, b_lcs;

  axis_frame_sink #(.WIDTH(4), .HEIGHT(2), .DATA_WIDTH(24), .LFSR_SEED(16'hACE1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .bp_enable(s_bp_en), .bp_thresh(s_bp_th), .err_clear(s_err_clr),
    .frame_done(s_done), .frame_count(s_fc), .last_pixel_count(s_lpc),
    .last_checksum(s_lcs), .busy(s_busy),
    .err_nosof(s_enosof), .err_sof(s_esof), .err_eof(s_eeof)
  );

  axis_frame_sink #(.WIDTH(128), .HEIGHT(100), .DATA_WIDTH(24), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tuser(b_tuser),
    .s_axis_tlast(b_tlast), .s_axis_tready(b_tready),
    .bp_enable(b_bp_en), .bp_thresh(b_bp_th), .err_clear(b_err_clr),
    .frame_done(b_done), .frame_count(b_fc), .last_pixel_count(b_lpc),
    .last_checksum(b_lcs), .busy(b_busy),
    .err_nosof(b_enosof), .err_sof(b_esof), .err_eof(b_eeof)
  );

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] sum;
    logic [15:0] fc;
    logic [2:0]  errs;   // {nosof, sof, eof}
  } exp_t;

  exp_t q_s[$];
  exp_t q_b[$];
  exp_t e_s, e_b;

  int n_vec  = 0;
  int n_miss = 0;
  int stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] c, input logic [31:0] s,
                              input logic [15:0] f, input logic [2:0] e);
    exp_t r;
    r.cnt = c; r.sum = s; r.fc = f; r.errs = e;
    return r;
  endfunction

  // Small-instance monitor: every frame_done pulse pops one expected frame.
  always @(negedge clk) begin
    if (s_done === 1'b1) begin
      if (q_s.size() == 0) begin
        check("s_unexpected_done", 32'd1, 32'd0);
      end else begin
        e_s = q_s.pop_front();
        check("s_pixel_count", s_lpc, e_s.cnt);
        check("s_checksum", s_lcs, e_s.sum);
        check("s_frame_count", 32'(s_fc), 32'(e_s.fc));
        check("s_err_flags", 32'({s_enosof, s_esof, s_eeof}), 32'(e_s.errs));
        check("s_busy_at_done", 32'(s_busy), 32'd0);
      end
    end
  end

  // Large-instance monitor.
  always @(negedge clk) begin
    if (b_done === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("b_pixel_count", b_lpc, e_b.cnt);
        check("b_checksum", b_lcs, e_b.sum);
        check("b_frame_count", 32'(b_fc), 32'(e_b.fc));
        check("b_err_flags", 32'({b_enosof, b_esof, b_eeof}), 32'(e_b.errs));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat on the small instance and hold it until accepted.
  task automatic s_beat(input logic [23:0] d, input logic u, input logic l);
    int  cyc;
    logic acc;
    s_tdata = d; s_tvalid = 1'b1; s_tuser = u; s_tlast = l;
    cyc = 0; acc = 1'b0;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) check("s_beat_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  // Same for the large instance; counts stall cycles seen.
  task automatic b_beat(input logic [23:0] d, input logic u, input logic l);
    int  cyc;
    logic acc;
    b_tdata = d; b_tvalid = 1'b1; b_tuser = u; b_tlast = l;
    cyc = 0; acc = 1'b0;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = b_tready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) check("b_beat_timeout", 32'd0, 32'd1);
    b_tvalid = 1'b0; b_tuser = 1'b0; b_tlast = 1'b0;
  endtask

  // Frame of n beats with consecutive data from first, SOF on beat 1, tlast on beat n.
  task automatic s_frame(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      s_beat(24'(first + i), (i == 0), (i == n - 1));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tready"}, 32'(s_tready), 32'd0);
    check({tag, "_done"}, 32'(s_done), 32'd0);
    check({tag, "_fc"}, 32'(s_fc), 32'd0);
    check({tag, "_lpc"}, s_lpc, 32'd0);
    check({tag, "_lcs"}, s_lcs, 32'd0);
    check({tag, "_busy"}, 32'(s_busy), 32'd0);
    check({tag, "_errs"}, 32'({s_enosof, s_esof, s_eeof}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_tdata = 24'd0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    s_bp_en = 1'b0; s_bp_th = 8'd0; s_err_clr = 1'b0;
    b_tdata = 24'd0; b_tvalid = 1'b0; b_tuser = 1'b0; b_tlast = 1'b0;
    b_bp_en = 1'b1; b_bp_th = 8'd128; b_err_clr = 1'b0;
    #1;
    tick(3);
    check_reset_state("rst");

    rst_n = 1'b1;
    tick(1);
    check("tready_after_reset", 32'(s_tready), 32'd1);

    // Good frame 1..8: checksum 36
    q_s.push_back(mk(32'd8, 32'h24, 16'd1, 3'b000));
    s_beat(24'd1, 1'b1, 1'b0);
    check("busy_after_sof", 32'(s_busy), 32'd1);
    for (int d = 2; d <= 8; d++) s_beat(24'(d), 1'b0, (d == 8));
    tick(2);
    check("busy_idle", 32'(s_busy), 32'd0);

    // Short frame (tlast on beat 6, data 10..15 = 75) back-to-back with a good frame
    q_s.push_back(mk(32'd6, 32'd75, 16'd2, 3'b001));
    q_s.push_back(mk(32'd8, 32'h24, 16'd3, 3'b001));
    s_frame(10, 6);
    s_frame(1, 8);
    tick(2);
    check("err_eof_sticky", 32'(s_eeof), 32'd1);

    // err_clear alone
    s_err_clr = 1'b1;
    tick(1);
    s_err_clr = 1'b0;
    check("clear_alone", 32'({s_enosof, s_esof, s_eeof}), 32'd0);

    // Beat without SOF in IDLE
    s_beat(24'd99, 1'b0, 1'b0);
    check("err_nosof", 32'(s_enosof), 32'd1);
    check("err_sof_quiet", 32'(s_esof), 32'd0);

    // SOF at beat 3 restarts: restarted frame is 5..12 = 68
    q_s.push_back(mk(32'd8, 32'd68, 16'd4, 3'b110));
    s_beat(24'd1, 1'b1, 1'b0);
    s_beat(24'd2, 1'b0, 1'b0);
    s_beat(24'd5, 1'b1, 1'b0);
    for (int d = 6; d <= 12; d++) s_beat(24'(d), 1'b0, (d == 12));
    tick(2);
    check("err_sof", 32'(s_esof), 32'd1);

    // Clear in the same cycle as a new nosof: nosof stays, sof clears
    s_err_clr = 1'b1;
    s_beat(24'd77, 1'b0, 1'b0);
    s_err_clr = 1'b0;
    check("clear_vs_set", 32'({s_enosof, s_esof, s_eeof}), 32'(3'b100));
    s_err_clr = 1'b1;
    tick(1);
    s_err_clr = 1'b0;

    // Reset after 5 beats of a frame
    for (int d = 1; d <= 5; d++) s_beat(24'(d), (d == 1), 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    q_s.push_back(mk(32'd8, 32'h24, 16'd1, 3'b000));
    s_frame(1, 8);
    tick(3);

    // Full default-size frame 0..12799 under 50% backpressure
    q_b.push_back(mk(32'd12800, 32'h04E1E700, 16'd1, 3'b000));
    for (int i = 0; i < 12800; i++) b_beat(24'(i), (i == 0), (i == 12799));
    check("b_tready_toggles", 32'(stalls > 0), 32'd1);
    tick(3);

    begin
      int w;
      w = 0;
      while ((q_s.size() != 0 || q_b.size() != 0) && w < 50) begin
        tick(1);
        w++;
      end
      check("queue_drain", 32'(q_s.size() + q_b.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axis_frame_sink.md
# axis_frame_sink

Synthesizable AXI4-Stream video sink that terminates the corrected-pixel output of `barrel_distortion_correction`. It drives `tready` with optional pseudo-random backpressure, checks frame framing (`tuser` = start of frame, `tlast` = end of frame), counts pixels and frames, and latches a per-frame additive checksum. It is used for on-chip self-test and for bench-independent stream checking.

## Interface
- `WIDTH`, 128, pixels per line
- `HEIGHT`, 100, lines per frame; expected frame size `N = WIDTH*HEIGHT`
- `DATA_WIDTH`, 24, pixel width (RGB888)
- `LFSR_SEED`, 16'hACE1, backpressure LFSR reset value; must be nonzero
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `s_axis_tdata`  in  DATA_WIDTH  pixel
- `s_axis_tvalid`  in  1  beat valid
- `s_axis_tuser`  in  1  start of frame
- `s_axis_tlast`  in  1  end of frame (last pixel of frame, not of line)
- `s_axis_tready`  out  1  sink ready (registered)
- `bp_enable`  in  1  enable random backpressure
- `bp_thresh`  in  8  stall when `lfsr[7:0] < bp_thresh`
- `err_clear`  in  1  clears sticky error flags
- `frame_done`  out  1  one-cycle pulse per closed frame
- `frame_count`  out  16  frames closed since reset, wraps at 2^16
- `last_pixel_count`  out  32  beats in last closed frame
- `last_checksum`  out  32  checksum of last closed frame
- `busy`  out  1  high while in ACTIVE
- `err_nosof`  out  1  sticky: beat accepted in IDLE without `tuser`
- `err_sof`  out  1  sticky: `tuser` accepted inside a frame
- `err_eof`  out  1  sticky: frame length mismatch

## Operation
- Accept = `s_axis_tvalid && s_axis_tready` at a rising edge; nothing else has effect.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every cycle after reset.
- `s_axis_tready` next = `!(bp_enable && lfsr[7:0] < bp_thresh)`; independent of `tvalid`. `bp_thresh = 0` never stalls; `bp_thresh = 255` stalls only when `lfsr[7:0] != 255`.
- Checksum: 32-bit sum of zero-extended `tdata`, mod 2^32. Pixel counter 32-bit.
- FSM states IDLE, ACTIVE.
  - IDLE, accept with `tuser=0`: beat dropped, set `err_nosof`.
  - IDLE, accept with `tuser=1`: count=1, sum=tdata; if `tlast` also set, close frame immediately (err_eof if N≠1), else -> ACTIVE.
  - ACTIVE, accept with `tuser=1`: set `err_sof`, discard current frame, restart as above (no `frame_done` for the discarded frame).
  - ACTIVE, accept with `tlast=1`: count+1, close frame; `err_eof` if count+1 ≠ N; -> IDLE.
  - ACTIVE, accept making count = N with `tlast=0`: set `err_eof`, close frame with count N; -> IDLE.
- Close frame: latch count/sum into `last_*`, `frame_count`++, pulse `frame_done`.
- `err_clear` clears all three flags; an error set in the same cycle wins.

## Timing
- Reset values: `s_axis_tready`=0, `frame_done`=0, `frame_count`=0, `last_pixel_count`=0, `last_checksum`=0, `busy`=0, all error flags 0, LFSR=`LFSR_SEED`, state IDLE.
- First edge after reset release: `tready` becomes 1 if `bp_enable`=0.
- `frame_done`, `last_*`, `frame_count` update on the edge after the closing accept (visible the cycle after that edge); `frame_done` high exactly one cycle.
- `busy` rises the cycle after the SOF accept, falls together with `frame_done`.
- Error flags assert the cycle after the offending accept.
- Reset asserted mid-frame: immediate return to reset values; partial frame discarded, no `frame_done`.
- Back-to-back frames: SOF may be accepted the cycle right after a closing accept; no dead cycle required.

## Test plan
- WIDTH=4, HEIGHT=2, bp off, pixels 1..8 with `tuser` on 1, `tlast` on 8, continuous valid -> one `frame_done`, `last_pixel_count`=8, `last_checksum`=0x24, `frame_count`=1, no errors.
- Default params, pixels 0..12799, `bp_thresh`=128, `bp_enable`=1 -> `tready` toggles; `last_checksum`=0x04E1E700, `last_pixel_count`=12800, no errors.
- WIDTH=4, HEIGHT=2, `tlast` on beat 6 -> `err_eof`=1, `last_pixel_count`=6; next correct frame gives `frame_count`=2.
- Beat without `tuser` in IDLE, then `tuser` at beat 3 of a frame -> `err_nosof`=1, `err_sof`=1, only the restarted frame reported.
- `err_clear` pulsed alone -> all flags 0 next cycle; pulsed in same cycle as a new error -> flag stays 1.
- Reset asserted after 5 beats of a frame -> all outputs at reset values, no `frame_done`; subsequent full frame reports `frame_count`=1.
